// File: rtl/flag_reg_decoder.sv
// flag_reg_decoder
// ----------------
// Flag register and branch-condition decoder for the ONC-16 CPU.
// The ALU status flags are captured into an internal register when the
// datapath asserts the data enable. A branch function code is decoded
// against the registered flags into a single branch-enable bit that the
// sequencer uses to take or skip a conditional jump.
//
// Parameters:
//   FR_FLAG_W  flag vector width (fixed at 4)
//   FR_FUNC_W  branch function code width (fixed at 4, 16 codes)
//
// Ports:
//   clock  in   system clock, rising-edge active
//   n_rst  in   synchronous active-low reset, clears the flag register
//   flags  in   ALU flags {S, Z, C, V} at bits [3:0]
//   func   in   branch condition code
//   de     in   data enable, capture flags at the next rising edge
//   bre    out  branch enable, 1 = condition true
module flag_reg_decoder #(
  parameter int unsigned FR_FLAG_W = 4,
  parameter int unsigned FR_FUNC_W = 4
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic [FR_FLAG_W-1:0] flags,
  input  logic [FR_FUNC_W-1:0] func,
  input  logic                 de,
  output logic                 bre
);

  typedef enum logic [3:0] {
    COND_ALW = 4'd0,
    COND_EQ  = 4'd1,
    COND_NE  = 4'd2,
    COND_CS  = 4'd3,
    COND_CC  = 4'd4,
    COND_MI  = 4'd5,
    COND_PL  = 4'd6,
    COND_VS  = 4'd7,
    COND_VC  = 4'd8,
    COND_HI  = 4'd9,
    COND_LS  = 4'd10,
    COND_GE  = 4'd11,
    COND_LT  = 4'd12,
    COND_GT  = 4'd13,
    COND_LE  = 4'd14,
    COND_NEV = 4'd15
  } cond_e;

  logic [FR_FLAG_W-1:0] fr;
  logic                 s_f, z_f, c_f, v_f;
  logic                 sv_eq;
  cond_e                cond;

  // Reset has priority over the data enable.
  always_ff @(posedge clock) begin
    if (!n_rst) begin
      fr <= '0;
    end else if (de) begin
      fr <= flags;
    end
  end

  assign s_f   = fr[3];
  assign z_f   = fr[2];
  assign c_f   = fr[1];
  assign v_f   = fr[0];
  assign sv_eq = s_f ~^ v_f;
  assign cond  = cond_e'(func);

  // Decode reads only the registered flags, never the live flags input.
  always_comb begin
    bre = 1'b0;
    unique case (cond)
      COND_ALW: bre = 1'b1;
      COND_EQ:  bre = z_f;
      COND_NE:  bre = ~z_f;
      COND_CS:  bre = c_f;
      COND_CC:  bre = ~c_f;
      COND_MI:  bre = s_f;
      COND_PL:  bre = ~s_f;
      COND_VS:  bre = v_f;
      COND_VC:  bre = ~v_f;
      COND_HI:  bre = c_f & ~z_f;
      COND_LS:  bre = ~c_f | z_f;
      COND_GE:  bre = sv_eq;
      COND_LT:  bre = ~sv_eq;
      COND_GT:  bre = ~z_f & sv_eq;
      COND_LE:  bre = z_f | ~sv_eq;
      COND_NEV: bre = 1'b0;
      default:  bre = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_flag_reg_decoder.sv
// Testbench for flag_reg_decoder. Stimulus steps push the expected branch
// enable for the current cycle into a scoreboard queue; a monitor on the
// falling edge pops each entry and compares it with bre.
module tb_flag_reg_decoder;

  logic       clock = 1'b0;
  logic       n_rst = 1'b0;
  logic       de    = 1'b0;
  logic [3:0] flags = '0;
  logic [3:0] func  = '0;
  logic       bre;

  always #5 clock = ~clock;

  flag_reg_decoder #(
    .FR_FLAG_W(4),
    .FR_FUNC_W(4)
  ) dut (
    .clock(clock),
    .n_rst(n_rst),
    .flags(flags),
    .func (func),
    .de   (de),
    .bre  (bre)
  );

  typedef struct packed {
    logic       exp;
    logic [3:0] fn;
    logic [3:0] fr;
    logic [7:0] tag;
  } item_t;

  item_t sbq[$];
  int    total = 0;
  int    bad   = 0;

  // Hand-built truth masks: bit i of truth[func] is bre for flag value i,
  // where i = {S, Z, C, V}.
  logic [15:0] truth [16] = '{
    16'hFFFF, // ALW
    16'hF0F0, // EQ
    16'h0F0F, // NE
    16'hCCCC, // CS
    16'h3333, // CC
    16'hFF00, // MI
    16'h00FF, // PL
    16'hAAAA, // VS
    16'h5555, // VC
    16'h0C0C, // HI
    16'hF3F3, // LS
    16'hAA55, // GE
    16'h55AA, // LT
    16'h0A05, // GT
    16'hF5FA, // LE
    16'h0000  // NEV
  };

  logic [3:0] mfr       = '0;
  logic       mfr_known = 1'b0;

  // One clock step: track what the edge did to the flag register, then
  // drive new inputs and queue the bre expected for this cycle.
  // hand >= 0 supplies a hand-computed expectation; -1 uses the truth masks.
  task automatic step(input logic r, input logic d, input logic [3:0] fl,
                      input logic [3:0] fn, input int hand,
                      input logic [7:0] tag);
    item_t       it;
    logic [15:0] row;
    @(posedge clock);
    if (!n_rst) begin
      mfr       = '0;
      mfr_known = 1'b1;
    end else if (de) begin
      mfr       = flags;
      mfr_known = 1'b1;
    end
    #1;
    n_rst = r;
    de    = d;
    flags = fl;
    func  = fn;
    if (mfr_known) begin
      row    = truth[fn];
      it.exp = (hand >= 0) ? hand[0] : row[mfr];
      it.fn  = fn;
      it.fr  = mfr;
      it.tag = tag;
      sbq.push_back(it);
    end
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clock);
      if (sbq.size() > 0) begin
        it = sbq.pop_front();
        total++;
        if (bre !== it.exp) begin
          bad++;
          $display("FAIL bre tag=%0d func=%0d fr=%b got=%b want=%b",
                   it.tag, it.fn, it.fr, bre, it.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset held with de=1 and varying flags; fr must stay zero.
    for (int i = 0; i < 17; i++)
      step(1'b0, 1'b1, 4'hF ^ 4'(i), 4'(i % 16), -1, 8'd1);

    // Exhaustive capture: every func against every flags value.
    for (int fn = 0; fn < 16; fn++)
      for (int fl = 0; fl < 16; fl++)
        step(1'b1, 1'b1, 4'(fl), 4'(fn), -1, 8'd2);
    step(1'b1, 1'b0, 4'h0, 4'd0, -1, 8'd2);

    // Z captured: EQ true, NE false.
    step(1'b1, 1'b1, 4'b0100, 4'd1, -1, 8'd3);
    step(1'b1, 1'b0, 4'b0000, 4'd1,  1, 8'd3);
    step(1'b1, 1'b0, 4'b0000, 4'd2,  0, 8'd3);

    // Hold: S,V captured, flags sweep with de=0 must not disturb fr.
    step(1'b1, 1'b1, 4'b1001, 4'd11, -1, 8'd4);
    for (int fl = 0; fl < 16; fl++)
      step(1'b1, 1'b0, 4'(fl), 4'd11, 1, 8'd4);
    step(1'b1, 1'b0, 4'b0000, 4'd12, 0, 8'd4);
    step(1'b1, 1'b0, 4'b1111, 4'd15, 0, 8'd4);

    // Signed compare.
    step(1'b1, 1'b1, 4'b1000, 4'd12, -1, 8'd5);
    step(1'b1, 1'b0, 4'b0000, 4'd12,  1, 8'd5);
    step(1'b1, 1'b0, 4'b0000, 4'd11,  0, 8'd5);
    step(1'b1, 1'b0, 4'b0000, 4'd13,  0, 8'd5);
    step(1'b1, 1'b0, 4'b0000, 4'd14,  1, 8'd5);
    step(1'b1, 1'b1, 4'b0000, 4'd13,  0, 8'd5);
    step(1'b1, 1'b0, 4'b1111, 4'd13,  1, 8'd5);

    // Unsigned compare.
    step(1'b1, 1'b1, 4'b0010, 4'd9,  -1, 8'd6);
    step(1'b1, 1'b0, 4'b0000, 4'd9,   1, 8'd6);
    step(1'b1, 1'b0, 4'b0000, 4'd10,  0, 8'd6);
    step(1'b1, 1'b1, 4'b0110, 4'd9,   1, 8'd6);
    step(1'b1, 1'b0, 4'b0000, 4'd9,   0, 8'd6);
    step(1'b1, 1'b0, 4'b0000, 4'd10,  1, 8'd6);

    // Reset mid-operation beats a simultaneous capture.
    step(1'b1, 1'b1, 4'b0100, 4'd1, -1, 8'd7);
    step(1'b0, 1'b1, 4'b0100, 4'd1,  1, 8'd7);
    step(1'b1, 1'b1, 4'b0100, 4'd1,  0, 8'd7);
    step(1'b1, 1'b0, 4'b0000, 4'd1,  1, 8'd7);

    // Let the monitor drain the queue.
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: entries left=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
